// File: rtl/key_level_ctrl.sv
// key_level_ctrl: two-key (step / clear) level controller.
// Each key is optionally inverted, synchronised and debounced. A debounced press
// becomes a step or clear event, which updates a 0..MAX_LEVEL counter in bounce
// (ping-pong) or wrap mode. Level, direction, one-hot vector and step strobe are
// all registered.
// Optional build macro: KEY_LED_CTRL_AUTO_REPEAT_EN adds hold-to-repeat on the step key.

// Per-key front end: inversion, 2-flop synchroniser, debouncer, press detect.
module key_level_ctrl_key #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int KEY_ACTIVE_LOW  = 0
) (
   input  logic I_clk,
   input  logic I_rst,
   input  logic I_key,
   output logic O_stable,
   output logic O_press
);
   localparam int   DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic INV  = (KEY_ACTIVE_LOW != 0);

   logic [1:0]      sync;
   logic [DB_W-1:0] db_cnt;
   logic            stable;
   logic            stable_d;

   // Sync, then require DEBOUNCE_CYCLES consecutive differing samples; the flip
   // happens on the edge where the count would reach DEBOUNCE_CYCLES.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         sync     <= '0;
         db_cnt   <= '0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
      end else begin
         sync     <= {sync[0], I_key ^ INV};
         stable_d <= stable;
         if (sync[1] == stable)
            db_cnt <= '0;
         else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync[1];
            db_cnt <= '0;
         end else
            db_cnt <= db_cnt + 1'b1;
      end
   end

   assign O_stable = stable;
   assign O_press  = stable & ~stable_d;
endmodule

module key_level_ctrl #(
   parameter int MAX_LEVEL       = 5,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int KEY_ACTIVE_LOW  = 0,
   parameter int REPEAT_DELAY    = 1000,
   parameter int REPEAT_PERIOD   = 250
) (
   input  logic                           I_clk,
   input  logic                           I_rst,
   input  logic                           I_key_step,
   input  logic                           I_key_clr,
   input  logic                           I_mode,
   output logic [$clog2(MAX_LEVEL+1)-1:0] O_level,
   output logic                           O_dir,
   output logic [MAX_LEVEL:0]             O_onehot,
   output logic                           O_step
);
   localparam int                CNT_W = $clog2(MAX_LEVEL + 1);
   localparam int                OH_W  = MAX_LEVEL + 1;
   localparam logic [CNT_W-1:0]  MAX_L = CNT_W'(MAX_LEVEL);

   // bit 0 = step key, bit 1 = clear key
   logic [1:0] keys_raw;
   logic [1:0] key_stable;
   logic [1:0] key_press;

   assign keys_raw = {I_key_clr, I_key_step};

   for (genvar k = 0; k < 2; k++) begin : g_key
      key_level_ctrl_key #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
      ) u_key (
         .I_clk   (I_clk),
         .I_rst   (I_rst),
         .I_key   (keys_raw[k]),
         .O_stable(key_stable[k]),
         .O_press (key_press[k])
      );
   end

   logic step_ev;
   logic clr_ev;
   logic unused_ok;

   assign clr_ev = key_press[1];

`ifdef KEY_LED_CTRL_AUTO_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   logic [RP_W-1:0] hold_cnt;
   logic            hold_rpt;
   logic            rpt_ev;

   // hold_cnt is 0 in the press-event cycle; the first repeat waits REPEAT_DELAY,
   // later ones REPEAT_PERIOD (counter restarts at 1 the cycle after a repeat).
   assign rpt_ev = key_stable[0] &&
                   (hold_rpt ? (hold_cnt == RP_W'(REPEAT_PERIOD))
                             : (hold_cnt == RP_W'(REPEAT_DELAY)));

   // Hold counter runs only while the step key is debounced-high.
   always_ff @(posedge I_clk) begin
      if (I_rst || !key_stable[0]) begin
         hold_cnt <= '0;
         hold_rpt <= 1'b0;
      end else if (rpt_ev) begin
         hold_cnt <= RP_W'(1);
         hold_rpt <= 1'b1;
      end else
         hold_cnt <= hold_cnt + 1'b1;
   end

   assign step_ev   = key_press[0] | rpt_ev;
   assign unused_ok = key_stable[1];
`else
   assign step_ev   = key_press[0];
   assign unused_ok = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD), key_stable};
`endif

   logic [CNT_W-1:0] lvl_nxt;
   logic             dir_nxt;
   logic             upd;

   // Next level/dir; clear has priority over step, mode is sampled per event.
   always_comb begin
      lvl_nxt = O_level;
      dir_nxt = O_dir;
      upd     = 1'b0;
      if (clr_ev) begin
         lvl_nxt = '0;
         dir_nxt = 1'b1;
         upd     = 1'b1;
      end else if (step_ev) begin
         upd = 1'b1;
         if (O_level > MAX_L) begin
            lvl_nxt = '0;
            dir_nxt = 1'b1;
         end else if (I_mode) begin
            lvl_nxt = (O_level == MAX_L) ? '0 : O_level + 1'b1;
            dir_nxt = 1'b1;
         end else if (O_dir) begin
            if (O_level == MAX_L) begin
               lvl_nxt = MAX_L - 1'b1;
               dir_nxt = 1'b0;
            end else
               lvl_nxt = O_level + 1'b1;
         end else begin
            if (O_level == '0) begin
               lvl_nxt = CNT_W'(1);
               dir_nxt = 1'b1;
            end else
               lvl_nxt = O_level - 1'b1;
         end
      end
   end

   // Output registers; one-hot is registered alongside the binary level.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         O_level  <= '0;
         O_dir    <= 1'b1;
         O_onehot <= OH_W'(1);
         O_step   <= 1'b0;
      end else begin
         O_level  <= lvl_nxt;
         O_dir    <= dir_nxt;
         O_onehot <= OH_W'(1) << lvl_nxt;
         O_step   <= upd;
      end
   end
endmodule

// File: tb/tb_key_level_ctrl.sv
// Self-checking bench for key_level_ctrl (MAX_LEVEL=5, DEBOUNCE_CYCLES=16).
// Reference model tracks a bounce phase p in 0..2*MAX: level is the triangle
// wave of p, dir is (p <= MAX); wrap mode maps the level straight back to p.
module tb_key_level_ctrl;
   localparam int MAXL = 5;
   localparam int DB   = 16;
   localparam int RD   = 20;
   localparam int RPER = 5;

   logic       I_clk = 1'b0;
   logic       I_rst;
   logic       I_key_step;
   logic       I_key_clr;
   logic       I_mode;
   logic [2:0] O_level;
   logic       O_dir;
   logic [5:0] O_onehot;
   logic       O_step;

   key_level_ctrl #(
      .MAX_LEVEL(MAXL), .DEBOUNCE_CYCLES(DB), .KEY_ACTIVE_LOW(0),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RPER)
   ) dut (
      .I_clk(I_clk), .I_rst(I_rst), .I_key_step(I_key_step), .I_key_clr(I_key_clr),
      .I_mode(I_mode), .O_level(O_level), .O_dir(O_dir), .O_onehot(O_onehot),
      .O_step(O_step)
   );

   always #5 I_clk = ~I_clk;

   int n_chk = 0;
   int n_fail = 0;
   int step_cnt = 0;
   int cyc = 0;
   int step_times[$];
   int p = 0;

   always @(posedge I_clk) cyc <= cyc + 1;
   always @(negedge I_clk) if (O_step === 1'b1) begin
      step_cnt++;
      step_times.push_back(cyc);
   end

   function automatic int m_level();
      return (p <= MAXL) ? p : 2 * MAXL - p;
   endfunction
   function automatic int m_dir();
      return (p <= MAXL) ? 1 : 0;
   endfunction
   task automatic m_step(input bit mode);
      if (mode) p = (m_level() == MAXL) ? 0 : m_level() + 1;
      else      p = (p == 2 * MAXL) ? 1 : p + 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int exp_steps);
      @(negedge I_clk);
      chk({tag, ".level"}, 32'(O_level), 32'(m_level()));
      chk({tag, ".dir"}, 32'(O_dir), 32'(m_dir()));
      chk({tag, ".onehot"}, 32'(O_onehot), 32'(1) << m_level());
      chk({tag, ".steps"}, 32'(step_cnt), 32'(exp_steps));
   endtask

   // leaves time at #1 after a rising edge
   task automatic tick(input int n);
      repeat (n) @(posedge I_clk);
      #1;
   endtask

   task automatic press(input bit clr, input bit stp, input int hold, input int gap);
      I_key_clr = clr;
      I_key_step = stp;
      tick(hold);
      I_key_clr = 1'b0;
      I_key_step = 1'b0;
      tick(gap);
   endtask

   initial begin
      int exp_steps;
      int r;
      bit md;
      I_rst = 1'b1; I_key_step = 1'b0; I_key_clr = 1'b0; I_mode = 1'b0;
      tick(3);
      I_rst = 1'b0;
      tick(5);
      exp_steps = 0;
      chk_state("reset", exp_steps);
      chk("reset.step", 32'(O_step), 32'd0);

      // bounce mode, 12 clean presses
      I_mode = 1'b0;
      for (int i = 0; i < 12; i++) begin
         press(1'b0, 1'b1, DB + 1 + $urandom_range(0, 2), DB + 4 + $urandom_range(0, 10));
         m_step(1'b0); exp_steps++;
         chk_state("bounce", exp_steps);
      end

      // clear, then wrap mode 7 presses
      press(1'b1, 1'b0, DB + 2, DB + 6);
      p = 0; exp_steps++;
      chk_state("clr0", exp_steps);
      I_mode = 1'b1;
      for (int i = 0; i < 7; i++) begin
         press(1'b0, 1'b1, DB + 1 + $urandom_range(0, 2), DB + 4 + $urandom_range(0, 10));
         m_step(1'b1); exp_steps++;
         chk_state("wrap", exp_steps);
      end

      // exact latency: 17-cycle high, O_step at edge N+18
      I_key_step = 1'b1;
      tick(17);
      I_key_step = 1'b0;
      @(posedge I_clk); @(negedge I_clk);
      chk("lat.n17", 32'(O_step), 32'd0);
      @(posedge I_clk); @(negedge I_clk);
      chk("lat.n18", 32'(O_step), 32'd1);
      m_step(1'b1); exp_steps++;
      tick(DB + 6);
      chk_state("lat", exp_steps);

      // 15-cycle glitch: nothing; 16-cycle: exactly one step
      press(1'b0, 1'b1, DB - 1, DB + 6);
      chk_state("glitch15", exp_steps);
      press(1'b0, 1'b1, DB, DB + 6);
      m_step(1'b1); exp_steps++;
      chk_state("pulse16", exp_steps);

      // chatter then hold: one step
      I_mode = 1'b0;
      I_key_step = 1'b1; tick(2);
      I_key_step = 1'b0; tick(2);
      I_key_step = 1'b1; tick(1);
      I_key_step = 1'b0; tick(1);
      press(1'b0, 1'b1, DB + 2, DB + 6);
      m_step(1'b0); exp_steps++;
      chk_state("chatter", exp_steps);

      // walk to level 3 going down, then step+clear together
      for (int i = 0; i < 12 && !(m_level() == 3 && m_dir() == 0); i++) begin
         press(1'b0, 1'b1, DB + 1, DB + 4);
         m_step(1'b0); exp_steps++;
      end
      chk_state("pre_clr", exp_steps);
      press(1'b1, 1'b1, DB + 2, DB + 6);
      p = 0; exp_steps++;
      chk_state("step_clr", exp_steps);

      // randomized mix of steps, clears, glitches and mode changes
      for (int i = 0; i < 24; i++) begin
         md = 1'($urandom_range(0, 1));
         I_mode = md;
         r = $urandom_range(0, 5);
         if (r == 0) begin
            press(1'b0, 1'b1, $urandom_range(1, DB - 1), DB + 4);
         end else if (r == 1) begin
            press(1'b1, 1'b0, DB + 1 + $urandom_range(0, 2), DB + 4 + $urandom_range(0, 8));
            p = 0; exp_steps++;
         end else begin
            press(1'b0, 1'b1, DB + 1 + $urandom_range(0, 2), DB + 4 + $urandom_range(0, 8));
            m_step(md); exp_steps++;
         end
         chk_state("rand", exp_steps);
      end

      // reset mid-debounce with key held through reset
      I_key_step = 1'b1;
      tick(8);
      I_rst = 1'b1;
      tick(2);
      I_rst = 1'b0;
      p = 0;
      chk_state("rst_mid", exp_steps);
      chk("rst_mid.step", 32'(O_step), 32'd0);
      md = I_mode;
      tick(DB + 3);
      I_key_step = 1'b0;
      tick(DB + 6);
      m_step(md); exp_steps++;
      chk_state("rst_held", exp_steps);

      // long hold in wrap mode
      I_mode = 1'b1;
      step_times.delete();
      press(1'b0, 1'b1, 40, DB + 10);
`ifdef KEY_LED_CTRL_AUTO_REPEAT_EN
      for (int i = 0; i < 5; i++) begin
         m_step(1'b1); exp_steps++;
      end
      chk_state("rpt", exp_steps);
      chk("rpt.n", 32'(step_times.size()), 32'd5);
      if (step_times.size() == 5) begin
         chk("rpt.d1", 32'(step_times[1] - step_times[0]), 32'(RD));
         for (int i = 2; i < 5; i++)
            chk("rpt.dn", 32'(step_times[i] - step_times[i-1]), 32'(RPER));
      end
`else
      m_step(1'b1); exp_steps++;
      chk_state("hold", exp_steps);
      chk("hold.n", 32'(step_times.size()), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
